// File: rtl/core_pkg.sv
// Shared constants and types for the register-file write-back path.
package core_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned NUM_REGS   = 32;

    // Names a write-back producer; used for the round-robin pointer and the age flag.
    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry holding register for a write-back producer.
// Writes to register 0 are accepted but never stored.
module wb_hold_slot #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_valid,
    input  logic [ADDR_WIDTH-1:0] i_rd,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_grant,
    output logic                  o_ready,
    output logic                  o_load,
    output logic                  o_held,
    output logic [ADDR_WIDTH-1:0] o_rd,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic                  r_valid;
    logic [ADDR_WIDTH-1:0] r_rd;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_valid_nxt;

    // Ready depends only on held state and this cycle's grant, never on i_valid.
    assign o_ready = ~r_valid | i_grant;
    assign o_load  = i_valid & o_ready & (i_rd != '0) & ~i_flush;
    assign o_held  = r_valid;
    assign o_rd    = r_rd;
    assign o_data  = r_data;

    // Next occupancy: flush wins, then a new load, then release on grant.
    always_comb begin
        w_valid_nxt = r_valid;
        if (i_flush) begin
            w_valid_nxt = 1'b0;
        end else if (o_load) begin
            w_valid_nxt = 1'b1;
        end else if (i_grant) begin
            w_valid_nxt = 1'b0;
        end
    end

    // Holding register state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_rd    <= '0;
            r_data  <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            if (o_load) begin
                r_rd   <= i_rd;
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between the ALU and load results.
// Round-robin between producers, but same-destination writes always retire in order.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_REGS   = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [ADDR_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  rf_wEn,
    output logic [ADDR_WIDTH-1:0] rf_write_sel,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    output logic [NUM_REGS-1:0]   pending_mask
);

    import core_pkg::*;

    logic                  w_alu_load, w_alu_held, w_alu_grant;
    logic [ADDR_WIDTH-1:0] w_alu_rd;
    logic [DATA_WIDTH-1:0] w_alu_data;
    logic                  w_mem_load, w_mem_held, w_mem_grant;
    logic [ADDR_WIDTH-1:0] w_mem_rd;
    logic [DATA_WIDTH-1:0] w_mem_data;
    logic                  w_rr_flip;
    logic                  w_issue;
    wb_src_e               r_rr_ptr;
    wb_src_e               r_age;
    wb_src_e               w_age_nxt;
    logic                  r_wen;
    logic [ADDR_WIDTH-1:0] r_sel;
    logic [DATA_WIDTH-1:0] r_data;

    wb_hold_slot #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_alu_slot (
        .i_clk  (clock),
        .i_rst_n(reset),
        .i_flush(flush),
        .i_valid(alu_valid),
        .i_rd   (alu_rd),
        .i_data (alu_data),
        .i_grant(w_alu_grant),
        .o_ready(alu_ready),
        .o_load (w_alu_load),
        .o_held (w_alu_held),
        .o_rd   (w_alu_rd),
        .o_data (w_alu_data)
    );

    wb_hold_slot #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem_slot (
        .i_clk  (clock),
        .i_rst_n(reset),
        .i_flush(flush),
        .i_valid(mem_valid),
        .i_rd   (mem_rd),
        .i_data (mem_data),
        .i_grant(w_mem_grant),
        .o_ready(mem_ready),
        .o_load (w_mem_load),
        .o_held (w_mem_held),
        .o_rd   (w_mem_rd),
        .o_data (w_mem_data)
    );

    // Grant selection: same-rd conflicts go to the older entry, otherwise round-robin.
    always_comb begin
        w_alu_grant = 1'b0;
        w_mem_grant = 1'b0;
        w_rr_flip   = 1'b0;
        if (w_alu_held && w_mem_held) begin
            if (w_alu_rd == w_mem_rd) begin
                w_alu_grant = (r_age == WB_ALU);
                w_mem_grant = (r_age == WB_MEM);
            end else begin
                w_rr_flip   = 1'b1;
                w_alu_grant = (r_rr_ptr == WB_ALU);
                w_mem_grant = (r_rr_ptr == WB_MEM);
            end
        end else begin
            w_alu_grant = w_alu_held;
            w_mem_grant = w_mem_held;
        end
    end

    // A grant in a flush cycle is dropped along with the held entry.
    assign w_issue = (w_alu_grant | w_mem_grant) & ~flush;

    // Age: which entry will be older once both slots hold something next cycle.
    always_comb begin
        w_age_nxt = r_age;
        if (flush) begin
            w_age_nxt = WB_ALU;
        end else if (w_alu_held && !w_alu_grant && w_mem_held && !w_mem_grant) begin
            w_age_nxt = r_age;
        end else if (w_alu_held && !w_alu_grant && w_mem_load) begin
            w_age_nxt = WB_ALU;
        end else if (w_mem_held && !w_mem_grant && w_alu_load) begin
            w_age_nxt = WB_MEM;
        end else if (w_alu_load && w_mem_load) begin
            // Same-edge acceptance: the load belongs to the earlier instruction.
            w_age_nxt = WB_MEM;
        end
    end

    // Arbitration state: round-robin pointer (kept across flush) and age flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= WB_ALU;
            r_age    <= WB_ALU;
        end else begin
            r_age <= w_age_nxt;
            if (w_rr_flip && !flush) begin
                r_rr_ptr <= (r_rr_ptr == WB_ALU) ? WB_MEM : WB_ALU;
            end
        end
    end

    // Registered write port toward the register file.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wen  <= 1'b0;
            r_sel  <= '0;
            r_data <= '0;
        end else begin
            r_wen <= w_issue;
            if (w_issue) begin
                r_sel  <= w_alu_grant ? w_alu_rd : w_mem_rd;
                r_data <= w_alu_grant ? w_alu_data : w_mem_data;
            end
        end
    end

    assign rf_wEn        = r_wen;
    assign rf_write_sel  = r_sel;
    assign rf_write_data = r_data;

    // Pending bitmap over held entries and the in-flight register-file write.
    always_comb begin
        pending_mask = '0;
        for (int i = 1; i < int'(NUM_REGS); i++) begin
            pending_mask[i] = (w_alu_held && (w_alu_rd == ADDR_WIDTH'(i)))
                            | (w_mem_held && (w_mem_rd == ADDR_WIDTH'(i)))
                            | (r_wen && (r_sel == ADDR_WIDTH'(i)));
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a sequence-numbered behavioural model.
module tb_regfile_wb_arbiter;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid, mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        rf_wEn;
    logic [4:0]  rf_write_sel;
    logic [31:0] rf_write_data;
    logic [31:0] pending_mask;

    regfile_wb_arbiter #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .NUM_REGS  (32)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .rf_wEn       (rf_wEn),
        .rf_write_sel (rf_write_sel),
        .rf_write_data(rf_write_data),
        .pending_mask (pending_mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register file fed by the DUT's write port.
    logic [31:0] rf_mem [32];
    always @(posedge clock) begin
        if (rf_wEn) rf_mem[rf_write_sel] <= rf_write_data;
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Behavioural model: each held entry carries a global acceptance sequence number.
    logic        ma_v, mm_v, mo_wen;
    logic [4:0]  ma_rd, mm_rd, mo_sel;
    logic [31:0] ma_d, mm_d, mo_data;
    int unsigned ma_seq, mm_seq, seq_ctr;
    int          m_rr;  // 0: ALU's turn, 1: MEM's turn

    task automatic model_reset();
        ma_v = 0; mm_v = 0; mo_wen = 0;
        ma_rd = 0; mm_rd = 0; mo_sel = 0;
        ma_d = 0; mm_d = 0; mo_data = 0;
        ma_seq = 0; mm_seq = 0; seq_ctr = 0; m_rr = 0;
    endtask

    // 0 = no grant, 1 = ALU, 2 = MEM
    function automatic int model_grant();
        if (ma_v && mm_v) begin
            if (ma_rd == mm_rd) return (ma_seq < mm_seq) ? 1 : 2;
            return (m_rr == 0) ? 1 : 2;
        end
        if (ma_v) return 1;
        if (mm_v) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] model_pending();
        logic [31:0] p;
        p = '0;
        if (ma_v) p[ma_rd] = 1'b1;
        if (mm_v) p[mm_rd] = 1'b1;
        if (mo_wen) p[mo_sel] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    // One cycle: compare outputs, drive inputs, advance model across the rising edge.
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                        input logic fl);
        int   g;
        logic er_a, er_m, flip;
        g    = model_grant();
        er_a = !ma_v || (g == 1);
        er_m = !mm_v || (g == 2);
        flip = ma_v && mm_v && (ma_rd != mm_rd);
        check("alu_ready", alu_ready, er_a);
        check("mem_ready", mem_ready, er_m);
        check("rf_wEn", rf_wEn, mo_wen);
        if (mo_wen) begin
            check("rf_write_sel", rf_write_sel, mo_sel);
            check("rf_write_data", rf_write_data, mo_data);
        end
        check("pending_mask", pending_mask, model_pending());
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        flush = fl;
        @(posedge clock);
        if (fl) begin
            ma_v = 0; mm_v = 0; mo_wen = 0;
        end else begin
            mo_wen = (g != 0);
            if (g == 1) begin mo_sel = ma_rd; mo_data = ma_d; ma_v = 0; end
            if (g == 2) begin mo_sel = mm_rd; mo_data = mm_d; mm_v = 0; end
            if (flip) m_rr = 1 - m_rr;
            if (mv && er_m && mrd != 0) begin
                mm_v = 1; mm_rd = mrd; mm_d = md; mm_seq = seq_ctr; seq_ctr++;
            end
            if (av && er_a && ard != 0) begin
                ma_v = 1; ma_rd = ard; ma_d = ad; ma_seq = seq_ctr; seq_ctr++;
            end
        end
        @(negedge clock);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        flush = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
        // Reset held low with a request pending.
        reset = 0;
        alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h55;
        #12;
        check("reset rf_wEn", rf_wEn, 1'b0);
        check("reset pending", pending_mask, 32'h0);
        #10;
        reset = 1;
        alu_valid = 0;
        #1;
        check("post-reset alu_ready", alu_ready, 1'b1);
        check("post-reset mem_ready", mem_ready, 1'b1);
        @(negedge clock);

        // Single ALU write.
        step(1, 5'd2, 32'hDEADBEEF, 0, 0, 0, 0);
        check("single pending held", pending_mask, 32'h4);
        idle();
        check("single rf_wEn", rf_wEn, 1'b1);
        check("single sel", rf_write_sel, 5'd2);
        check("single data", rf_write_data, 32'hDEADBEEF);
        check("single pending rf", pending_mask, 32'h4);
        idle();
        check("single done wEn", rf_wEn, 1'b0);
        check("single done pending", pending_mask, 32'h0);

        // Different-rd contention: ALU first, then the pointer alternates.
        step(1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 0);
        idle();
        check("rr1 first sel", rf_write_sel, 5'd3);
        check("rr1 first data", rf_write_data, 32'h11);
        idle();
        check("rr1 second sel", rf_write_sel, 5'd4);
        check("rr1 second data", rf_write_data, 32'h22);
        step(1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 0);
        idle();
        check("rr2 first sel", rf_write_sel, 5'd4);
        idle();
        check("rr2 second sel", rf_write_sel, 5'd3);
        idle();

        // Same-rd ordering: MEM older on same-edge acceptance.
        step(1, 5'd5, 32'hBB, 1, 5'd5, 32'hAA, 0);
        idle();
        check("samerd first data", rf_write_data, 32'hAA);
        idle();
        check("samerd second data", rf_write_data, 32'hBB);
        idle();
        idle();
        check("samerd rf readback", rf_mem[5], 32'hBB);

        // Register 0 is dropped.
        step(1, 5'd0, 32'h1234, 0, 0, 0, 0);
        check("x0 wEn", rf_wEn, 1'b0);
        check("x0 pending", pending_mask, 32'h0);
        check("x0 ready", alu_ready, 1'b1);
        idle();
        check("x0 wEn later", rf_wEn, 1'b0);

        // Flush discards both held entries.
        step(1, 5'd6, 32'h66, 1, 5'd7, 32'h77, 0);
        check("preflush pending", pending_mask, 32'hC0);
        step(0, 0, 0, 0, 0, 0, 1);
        check("flush pending", pending_mask, 32'h0);
        check("flush wEn", rf_wEn, 1'b0);
        check("flush alu_ready", alu_ready, 1'b1);
        check("flush mem_ready", mem_ready, 1'b1);
        idle();

        // Random traffic with small rd range for collisions and x0 requests.
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 19) == 0));
        end

        // Asynchronous reset mid-operation.
        step(1, 5'd9, 32'h99, 1, 5'd10, 32'hA0, 0);
        #1 reset = 0;
        #1;
        check("async reset wEn", rf_wEn, 1'b0);
        check("async reset pending", pending_mask, 32'h0);
        check("async reset alu_ready", alu_ready, 1'b1);
        check("async reset sel", rf_write_sel, 5'd0);
        alu_valid = 0; mem_valid = 0;
        reset = 1;
        model_reset();
        idle();
        idle();
        check("after async reset wEn", rf_wEn, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
